// File: rtl/alu_cdb_unit.sv
// RV32I integer/branch execution unit: one-deep issue register, 2-entry result FIFO,
// and in-order broadcast of results on the common data bus.
module alu_cdb_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              stall_out,
    input  logic [OP_W-1:0]   op_in,
    input  logic [DATA_W-1:0] v1_in,
    input  logic [DATA_W-1:0] v2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              cdb_valid,
    input  logic              cdb_grant,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [DATA_W-1:0] cdb_target,
    output logic              cdb_taken
);

    localparam logic [4:0] FnNop   = 5'd0;
    localparam logic [4:0] FnAdd   = 5'd1;
    localparam logic [4:0] FnSub   = 5'd2;
    localparam logic [4:0] FnSll   = 5'd3;
    localparam logic [4:0] FnSlt   = 5'd4;
    localparam logic [4:0] FnSltu  = 5'd5;
    localparam logic [4:0] FnXor   = 5'd6;
    localparam logic [4:0] FnSrl   = 5'd7;
    localparam logic [4:0] FnSra   = 5'd8;
    localparam logic [4:0] FnOr    = 5'd9;
    localparam logic [4:0] FnAnd   = 5'd10;
    localparam logic [4:0] FnLui   = 5'd11;
    localparam logic [4:0] FnAuipc = 5'd12;
    localparam logic [4:0] FnJal   = 5'd13;
    localparam logic [4:0] FnJalr  = 5'd14;
    localparam logic [4:0] FnBeq   = 5'd15;
    localparam logic [4:0] FnBne   = 5'd16;
    localparam logic [4:0] FnBlt   = 5'd17;
    localparam logic [4:0] FnBge   = 5'd18;
    localparam logic [4:0] FnBltu  = 5'd19;
    localparam logic [4:0] FnBgeu  = 5'd20;

    // Stage-1 issue register
    logic              st_valid_q, st_valid_d;
    logic [OP_W-1:0]   st_op_q, st_op_d;
    logic [DATA_W-1:0] st_v1_q, st_v1_d;
    logic [DATA_W-1:0] st_v2_q, st_v2_d;
    logic [DATA_W-1:0] st_imm_q, st_imm_d;
    logic [DATA_W-1:0] st_pc_q, st_pc_d;
    logic [TAG_W-1:0]  st_tag_q, st_tag_d;

    // Result FIFO
    logic [TAG_W-1:0]  fifo_tag_q[2], fifo_tag_d[2];
    logic [DATA_W-1:0] fifo_data_q[2], fifo_data_d[2];
    logic [DATA_W-1:0] fifo_target_q[2], fifo_target_d[2];
    logic              fifo_taken_q[2], fifo_taken_d[2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic [4:0]        fn;
    logic [DATA_W-1:0] op2;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] pc_plus_imm;
    logic              br_cond;
    logic [DATA_W-1:0] res_data;
    logic [DATA_W-1:0] res_target;
    logic              res_taken;
    logic [2:0]        occupancy;
    logic              accept;
    logic              push;
    logic              pop;

    assign fn          = st_op_q[4:0];
    assign op2         = st_op_q[5] ? st_imm_q : st_v2_q;
    assign shamt       = op2[4:0];
    assign pc_plus4    = st_pc_q + DATA_W'(4);
    assign pc_plus_imm = st_pc_q + st_imm_q;

    // Branches always compare the two register operands, never the immediate.
    always_comb begin
        br_cond = 1'b0;
        case (fn)
            FnBeq:   br_cond = (st_v1_q == st_v2_q);
            FnBne:   br_cond = (st_v1_q != st_v2_q);
            FnBlt:   br_cond = ($signed(st_v1_q) < $signed(st_v2_q));
            FnBge:   br_cond = ($signed(st_v1_q) >= $signed(st_v2_q));
            FnBltu:  br_cond = (st_v1_q < st_v2_q);
            FnBgeu:  br_cond = (st_v1_q >= st_v2_q);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        res_data   = '0;
        res_target = pc_plus4;
        res_taken  = 1'b0;
        case (fn)
            FnAdd:   res_data = st_v1_q + op2;
            FnSub:   res_data = st_v1_q - op2;
            FnSll:   res_data = st_v1_q << shamt;
            FnSlt:   res_data = {{(DATA_W-1){1'b0}}, $signed(st_v1_q) < $signed(op2)};
            FnSltu:  res_data = {{(DATA_W-1){1'b0}}, st_v1_q < op2};
            FnXor:   res_data = st_v1_q ^ op2;
            FnSrl:   res_data = st_v1_q >> shamt;
            FnSra:   res_data = $signed(st_v1_q) >>> shamt;
            FnOr:    res_data = st_v1_q | op2;
            FnAnd:   res_data = st_v1_q & op2;
            FnLui:   res_data = st_imm_q;
            FnAuipc: res_data = pc_plus_imm;
            FnJal: begin
                res_data   = pc_plus4;
                res_target = pc_plus_imm;
                res_taken  = 1'b1;
            end
            FnJalr: begin
                res_data   = pc_plus4;
                res_target = (st_v1_q + st_imm_q) & ~DATA_W'(1);
                res_taken  = 1'b1;
            end
            FnBeq, FnBne, FnBlt, FnBge, FnBltu, FnBgeu: begin
                res_taken  = br_cond;
                res_target = br_cond ? pc_plus_imm : pc_plus4;
            end
            default: ;
        endcase
    end

    // Occupancy comes from registers only, so in_ready never depends on cdb_grant.
    assign occupancy = {1'b0, count_q} + {2'b00, st_valid_q};
    assign in_ready  = (occupancy < 3'd2);
    assign stall_out = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign push      = st_valid_q && (fn != FnNop);
    assign pop       = cdb_valid && cdb_grant;

    always_comb begin
        st_valid_d    = st_valid_q;
        st_op_d       = st_op_q;
        st_v1_d       = st_v1_q;
        st_v2_d       = st_v2_q;
        st_imm_d      = st_imm_q;
        st_pc_d       = st_pc_q;
        st_tag_d      = st_tag_q;
        fifo_tag_d    = fifo_tag_q;
        fifo_data_d   = fifo_data_q;
        fifo_target_d = fifo_target_q;
        fifo_taken_d  = fifo_taken_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (flush_in) begin
            st_valid_d = 1'b0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            count_d    = 2'd0;
        end else begin
            st_valid_d = accept;
            if (accept) begin
                st_op_d  = op_in;
                st_v1_d  = v1_in;
                st_v2_d  = v2_in;
                st_imm_d = imm_in;
                st_pc_d  = pc_in;
                st_tag_d = tag_in;
            end
            if (push) begin
                fifo_tag_d[wr_ptr_q]    = st_tag_q;
                fifo_data_d[wr_ptr_q]   = res_data;
                fifo_target_d[wr_ptr_q] = res_target;
                fifo_taken_d[wr_ptr_q]  = res_taken;
                wr_ptr_d                = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid_q    <= 1'b0;
            st_op_q       <= '0;
            st_v1_q       <= '0;
            st_v2_q       <= '0;
            st_imm_q      <= '0;
            st_pc_q       <= '0;
            st_tag_q      <= '0;
            fifo_tag_q    <= '{default: '0};
            fifo_data_q   <= '{default: '0};
            fifo_target_q <= '{default: '0};
            fifo_taken_q  <= '{default: 1'b0};
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            st_valid_q    <= st_valid_d;
            st_op_q       <= st_op_d;
            st_v1_q       <= st_v1_d;
            st_v2_q       <= st_v2_d;
            st_imm_q      <= st_imm_d;
            st_pc_q       <= st_pc_d;
            st_tag_q      <= st_tag_d;
            fifo_tag_q    <= fifo_tag_d;
            fifo_data_q   <= fifo_data_d;
            fifo_target_q <= fifo_target_d;
            fifo_taken_q  <= fifo_taken_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Outputs are forced to zero while the FIFO is empty.
    assign cdb_valid  = (count_q != 2'd0);
    assign cdb_tag    = cdb_valid ? fifo_tag_q[rd_ptr_q] : '0;
    assign cdb_data   = cdb_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign cdb_target = cdb_valid ? fifo_target_q[rd_ptr_q] : '0;
    assign cdb_taken  = cdb_valid ? fifo_taken_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Bench for alu_cdb_unit: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the stage slot and result FIFO.
module tb_alu_cdb_unit;

    logic        clk;
    logic        rst;
    logic        flush_in;
    logic        in_valid;
    logic        in_ready;
    logic        stall_out;
    logic [5:0]  op_in;
    logic [31:0] v1_in, v2_in, imm_in, pc_in;
    logic [3:0]  tag_in;
    logic        cdb_valid;
    logic        cdb_grant;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [31:0] cdb_target;
    logic        cdb_taken;

    alu_cdb_unit #(.DATA_W(32), .TAG_W(4), .OP_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_in   (flush_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .stall_out  (stall_out),
        .op_in      (op_in),
        .v1_in      (v1_in),
        .v2_in      (v2_in),
        .imm_in     (imm_in),
        .pc_in      (pc_in),
        .tag_in     (tag_in),
        .cdb_valid  (cdb_valid),
        .cdb_grant  (cdb_grant),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .cdb_target (cdb_target),
        .cdb_taken  (cdb_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [31:0] target;
        logic        taken;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t mq[$];
    bit   m_st_v;
    logic [5:0]  m_op;
    logic [31:0] m_v1, m_v2, m_imm, m_pc;
    logic [3:0]  m_tag;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic res_t calc(input logic [5:0] op, input logic [31:0] v1,
                                  input logic [31:0] v2, input logic [31:0] imm,
                                  input logic [31:0] pc, input logic [3:0] tag);
        res_t        r;
        logic [31:0] b;
        int          s1, s2, sb, sh;
        bit          c;
        b  = op[5] ? imm : v2;
        s1 = v1;
        s2 = v2;
        sb = b;
        sh = b % 32;
        c  = 0;
        r.tag    = tag;
        r.data   = 32'd0;
        r.target = pc + 32'd4;
        r.taken  = 1'b0;
        case (int'(op % 32))
            1:  r.data = v1 + b;
            2:  r.data = v1 - b;
            3:  r.data = v1 << sh;
            4:  r.data = (s1 < sb) ? 32'd1 : 32'd0;
            5:  r.data = (v1 < b) ? 32'd1 : 32'd0;
            6:  r.data = v1 ^ b;
            7:  r.data = v1 >> sh;
            8:  r.data = s1 >>> sh;
            9:  r.data = v1 | b;
            10: r.data = v1 & b;
            11: r.data = imm;
            12: r.data = pc + imm;
            13: begin r.data = pc + 32'd4; r.target = pc + imm; r.taken = 1'b1; end
            14: begin
                r.data   = pc + 32'd4;
                r.target = (v1 + imm) - ((v1 + imm) % 2);
                r.taken  = 1'b1;
            end
            15, 16, 17, 18, 19, 20: begin
                case (int'(op % 32))
                    15:      c = (v1 == v2);
                    16:      c = (v1 != v2);
                    17:      c = (s1 < s2);
                    18:      c = (s1 >= s2);
                    19:      c = (v1 < v2);
                    default: c = (v1 >= v2);
                endcase
                r.taken  = c;
                r.target = c ? pc + imm : pc + 32'd4;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Compare all outputs to the model, then advance DUT and model by one edge.
    task automatic step();
        bit   exp_rdy;
        res_t head;
        exp_rdy = (mq.size() + (m_st_v ? 1 : 0)) < 2;
        head    = (mq.size() > 0) ? mq[0] : '0;
        check("in_ready", in_ready, exp_rdy);
        check("stall_out", stall_out, !exp_rdy);
        check("cdb_valid", cdb_valid, mq.size() > 0);
        check("cdb_tag", cdb_tag, head.tag);
        check("cdb_data", cdb_data, head.data);
        check("cdb_target", cdb_target, head.target);
        check("cdb_taken", cdb_taken, head.taken);
        @(posedge clk);
        if (flush_in) begin
            mq.delete();
            m_st_v = 0;
        end else begin
            if (mq.size() > 0 && cdb_grant) void'(mq.pop_front());
            if (m_st_v && (m_op % 32) != 0) mq.push_back(calc(m_op, m_v1, m_v2, m_imm, m_pc, m_tag));
            m_st_v = in_valid && exp_rdy;
            if (m_st_v) begin
                m_op = op_in; m_v1 = v1_in; m_v2 = v2_in;
                m_imm = imm_in; m_pc = pc_in; m_tag = tag_in;
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        op_in = op; v1_in = v1; v2_in = v2; imm_in = imm; pc_in = pc; tag_in = tag;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_rdy"}, in_ready, 1);
        check({name, "_vld"}, cdb_valid, 0);
        check({name, "_tag"}, cdb_tag, 0);
        check({name, "_data"}, cdb_data, 0);
        check({name, "_tgt"}, cdb_target, 0);
        check({name, "_tkn"}, cdb_taken, 0);
    endtask

    initial begin
        logic [4:0]  f;
        logic [31:0] a;
        rst = 1'b1; flush_in = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
        op_in = '0; v1_in = '0; v2_in = '0; imm_in = '0; pc_in = '0; tag_in = '0;
        m_st_v = 0;
        @(negedge clk);
        check_zero_outputs("reset");
        check("reset_stall", stall_out, 0);
        rst = 1'b0;

        // ADD then SUB with immediate, grant held
        cdb_grant = 1'b1;
        issue(6'd1, 32'd5, 32'd7, 32'd0, 32'h0, 4'd3);
        step();
        check("add_vld", cdb_valid, 1);
        check("add_tag", cdb_tag, 3);
        check("add_data", cdb_data, 12);
        issue(6'h22, 32'd1, 32'd0, 32'd2, 32'h0, 4'd4);
        step();
        check("sub_data", cdb_data, 32'hFFFF_FFFF);

        // Branches and jumps
        issue(6'd17, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd5);
        step();
        check("blt_taken", cdb_taken, 1);
        check("blt_target", cdb_target, 32'h120);
        issue(6'd19, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd6);
        step();
        check("bltu_taken", cdb_taken, 0);
        check("bltu_target", cdb_target, 32'h104);
        issue(6'd14, 32'h203, 32'd0, 32'd0, 32'h40, 4'd7);
        step();
        check("jalr_data", cdb_data, 32'h44);
        check("jalr_target", cdb_target, 32'h202);
        step();

        // Back-pressure: three back-to-back packets with grant low
        cdb_grant = 1'b0;
        issue(6'd1, 32'd1, 32'd1, 32'd0, 32'h0, 4'd8);
        issue(6'd1, 32'd2, 32'd2, 32'd0, 32'h0, 4'd9);
        check("bp_ready", in_ready, 0);
        check("bp_stall", stall_out, 1);
        issue(6'd1, 32'd3, 32'd3, 32'd0, 32'h0, 4'd10);
        cdb_grant = 1'b1;
        check("bp_first", cdb_tag, 8);
        step();
        check("bp_second", cdb_tag, 9);
        step();
        check("bp_empty", cdb_valid, 0);

        // Streaming: push and pop every cycle
        for (int i = 0; i < 6; i++) issue(6'd6, $urandom, $urandom, 32'd0, 32'h0, 4'(i + 1));
        repeat (2) step();

        // Flush with two results buffered and a packet offered in the flush cycle
        cdb_grant = 1'b0;
        issue(6'd9, 32'd1, 32'd2, 32'd0, 32'h0, 4'd11);
        issue(6'd9, 32'd3, 32'd4, 32'd0, 32'h0, 4'd12);
        step();
        check("pre_flush_vld", cdb_valid, 1);
        flush_in = 1'b1;
        cdb_grant = 1'b1;
        issue(6'd1, 32'd9, 32'd9, 32'd0, 32'h0, 4'd13);
        flush_in = 1'b0;
        check("flush_vld", cdb_valid, 0);
        check("flush_rdy", in_ready, 1);
        repeat (3) step();

        // Asynchronous reset mid-run with FIFO full
        cdb_grant = 1'b0;
        issue(6'd1, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
        issue(6'd1, 32'd1, 32'd1, 32'd0, 32'h0, 4'd2);
        step();
        check("full_vld", cdb_valid, 1);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        mq.delete();
        m_st_v = 0;
        @(negedge clk);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            f = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 20));
            a = $urandom;
            op_in     = {a[31], f};
            v1_in     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            v2_in     = ($urandom_range(0, 3) == 0) ? v1_in : $urandom;
            imm_in    = $urandom;
            pc_in     = $urandom;
            tag_in    = 4'($urandom_range(1, 15));
            in_valid  = ($urandom_range(0, 3) != 0);
            cdb_grant = ($urandom_range(0, 2) != 0);
            flush_in  = ($urandom_range(0, 39) == 0);
            step();
        end
        in_valid = 1'b0;
        flush_in = 1'b0;
        cdb_grant = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
